// File: rtl/iter_div_pkg.sv
// Shared definitions for the iterative restoring divider.
package iter_div_pkg;

  // Controller states; the numeric codes are visible on the CS debug port.
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    CHECK = 3'b001,
    CALC  = 3'b010,
    DONE  = 3'b011
  } state_t;

  localparam int unsigned DEF_WIDTH = 4;

  // Step counter must hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

  localparam int unsigned DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/iter_div_step.sv
// One combinational restoring-division step: shift, trial subtract, restore.
module div_step
  import iter_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   racc,
  input  logic [WIDTH-1:0] qacc,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   racc_next,
  output logic [WIDTH-1:0] qacc_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             fits;

  // Shift the {Racc,Qacc} pair left and decide whether the divisor fits.
  // The bit shifted out of Racc is part of the full-width comparison, so a
  // set bit there means the shifted value exceeds any divisor.
  always_comb begin
    shifted   = {racc[WIDTH-1:0], qacc[WIDTH-1]};
    trial     = {1'b0, shifted} - {2'b00, divisor};
    fits      = racc[WIDTH] | ~trial[WIDTH+1];
    racc_next = fits ? trial[WIDTH:0] : shifted;
    qacc_next = {qacc[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/iter_div.sv
// Multi-cycle restoring divider: one quotient bit per clock, Done pulse at end.
module iter_div
  import iter_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             Go,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             Err,
  output logic             Done,
  output logic [2:0]       CS
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   racc;
  logic [WIDTH-1:0] qacc;
  logic [CW-1:0]    cnt;
  logic             err;
  logic [WIDTH:0]   racc_n;
  logic [WIDTH-1:0] qacc_n;

  div_step #(.WIDTH(WIDTH)) u_step (
    .racc      (racc),
    .qacc      (qacc),
    .divisor   (dvs),
    .racc_next (racc_n),
    .qacc_next (qacc_n)
  );

  assign Q   = qacc;
  assign R   = racc[WIDTH-1:0];
  assign Err = err;

  // State register.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic and Moore outputs; unused codes fall back to IDLE.
  always_comb begin
    nxt  = state;
    Done = 1'b0;
    CS   = state;
    case (state)
      IDLE:    if (Go) nxt = CHECK;
      CHECK:   nxt = (dvs == '0) ? DONE : CALC;
      CALC:    if (cnt == CW'(1)) nxt = DONE;
      DONE: begin
        Done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Operand latching, working registers and step counter.
  // Q is cleared on acceptance and only takes the dividend when CALC begins,
  // so the divide-by-zero path never exposes the dividend on Q.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      dvd  <= '0;
      dvs  <= '0;
      racc <= '0;
      qacc <= '0;
      cnt  <= '0;
      err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Go) begin
            dvd  <= X;
            dvs  <= Y;
            racc <= '0;
            qacc <= '0;
            err  <= 1'b0;
            cnt  <= CW'(WIDTH);
          end
        end
        CHECK: begin
          if (dvs == '0) begin
            err  <= 1'b1;
            qacc <= '0;
            racc <= {1'b0, dvd};
          end else begin
            qacc <= dvd;
            racc <= '0;
          end
        end
        CALC: begin
          racc <= racc_n;
          qacc <= qacc_n;
          cnt  <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div.sv
// Self-checking bench for iter_div: arithmetic reference model plus directed vectors.
module tb_iter_div;

  localparam int W = 4;

  logic       CLK = 1'b0;
  logic       rst;
  logic       Go;
  logic [3:0] X, Y, Q, R;
  logic       Err, Done;
  logic [2:0] CS;

  iter_div #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .rst  (rst),
    .Go   (Go),
    .X    (X),
    .Y    (Y),
    .Q    (Q),
    .R    (R),
    .Err  (Err),
    .Done (Done),
    .CS   (CS)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int acc;   // edge number at which Go was accepted
    int dk;    // edges after acceptance until the DONE cycle
    int q;
    int r;
    int e;
  } exp_t;

  exp_t eq[$];
  int total = 0;
  int bad = 0;
  int edge_n = 0;
  int free_at = 0;
  int go_edge = 0;
  int done_cnt = 0;
  int last_q = 0, last_r = 0, last_e = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: decides acceptance and the expected result from arithmetic.
  initial begin : model
    exp_t t;
    forever begin
      @(posedge CLK);
      edge_n++;
      if (rst) begin
        eq.delete();
        free_at = 0;
      end else if (Go === 1'b1 && edge_n >= free_at) begin
        t.acc = edge_n;
        if (Y == 0) begin
          t.dk = 1;
          t.q  = 0;
          t.r  = int'(X);
          t.e  = 1;
        end else begin
          t.dk = W + 1;
          t.q  = int'(X) / int'(Y);
          t.r  = int'(X) % int'(Y);
          t.e  = 0;
        end
        eq.push_back(t);
        free_at = edge_n + t.dk + 2;
      end
    end
  end

  // Per-cycle comparison of CS, Done and the result registers against the model.
  initial begin : cmp
    int k;
    forever begin
      @(negedge CLK);
      if (Done === 1'b1) done_cnt++;
      if (eq.size() == 0) begin
        chk("cs_idle", CS, 0);
        chk("done_idle", Done, 0);
        chk("q_hold", Q, last_q);
        chk("r_hold", R, last_r);
        chk("err_hold", Err, last_e);
      end else begin
        k = edge_n - eq[0].acc;
        chk("cs_walk", CS, (k == eq[0].dk) ? 3 : ((k == 0) ? 1 : 2));
        chk("done_time", Done, (k == eq[0].dk) ? 1 : 0);
        if (k == 0) begin
          chk("q_clear", Q, 0);
          chk("r_clear", R, 0);
          chk("err_clear", Err, 0);
        end
        if (k >= eq[0].dk) begin
          chk("q_result", Q, eq[0].q);
          chk("r_result", R, eq[0].r);
          chk("err_result", Err, eq[0].e);
          last_q = eq[0].q;
          last_r = eq[0].r;
          last_e = eq[0].e;
          void'(eq.pop_front());
        end
      end
    end
  end

  task automatic start(input int x, input int y);
    @(posedge CLK);
    #2;
    X  = 4'(x);
    Y  = 4'(y);
    Go = 1'b1;
    @(posedge CLK);
    #1;
    go_edge = edge_n;
    #1;
    Go = 1'b0;
    X  = 4'($urandom_range(15, 0));
    Y  = 4'($urandom_range(15, 0));
  endtask

  task automatic wait_done(input string nm, output int lat);
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK);
      if (Done === 1'b1) begin
        lat = edge_n - go_edge;
        break;
      end
    end
    chk({nm, "_timeout"}, (lat >= 0) ? 1 : 0, 1);
  endtask

  task automatic lit(input string nm, input int x, input int y,
                     input int eqv, input int erv, input int eev, input int elat);
    int lat;
    start(x, y);
    wait_done(nm, lat);
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_q"}, Q, eqv);
    chk({nm, "_r"}, R, erv);
    chk({nm, "_err"}, Err, eev);
  endtask

  initial begin : stim
    int lat;
    int d0;
    rst = 1'b1;
    Go  = 1'b0;
    X   = '0;
    Y   = '0;
    #1;
    chk("rst_cs", CS, 0);
    chk("rst_q", Q, 0);
    chk("rst_r", R, 0);
    chk("rst_err", Err, 0);
    chk("rst_done", Done, 0);
    repeat (2) @(posedge CLK);
    #2 rst = 1'b0;

    // Hand-computed directed vectors.
    lit("d13_4", 13, 4, 3, 1, 0, 5);
    lit("d15_1", 15, 1, 15, 0, 0, 5);
    lit("d3_7", 3, 7, 0, 3, 0, 5);
    lit("d15_15", 15, 15, 1, 0, 0, 5);
    lit("d9_0", 9, 0, 0, 9, 1, 1);
    lit("d8_2", 8, 2, 4, 0, 0, 5);

    // Go held for 3 cycles, re-pulsed during CALC, operands changed mid-run.
    repeat (3) @(posedge CLK);
    d0 = done_cnt;
    #2;
    X  = 4'd11;
    Y  = 4'd2;
    Go = 1'b1;
    @(posedge CLK);
    #1 go_edge = edge_n;
    repeat (2) @(posedge CLK);
    #2;
    Go = 1'b0;
    X  = 4'd3;
    Y  = 4'd1;
    @(posedge CLK);
    #2;
    Go = 1'b1;
    X  = 4'd7;
    Y  = 4'd3;
    @(posedge CLK);
    #2;
    Go = 1'b0;
    X  = 4'd0;
    Y  = 4'd0;
    wait_done("busy", lat);
    chk("busy_lat", lat, 5);
    chk("busy_q", Q, 5);
    chk("busy_r", R, 1);
    chk("busy_err", Err, 0);
    repeat (12) @(negedge CLK);
    chk("busy_one_done", done_cnt - d0, 1);

    // Reset during the third CALC cycle.
    start(12, 5);
    repeat (3) @(posedge CLK);
    #2;
    rst = 1'b1;
    eq.delete();
    last_q = 0;
    last_r = 0;
    last_e = 0;
    #1;
    chk("mid_rst_cs", CS, 0);
    chk("mid_rst_q", Q, 0);
    chk("mid_rst_r", R, 0);
    chk("mid_rst_err", Err, 0);
    chk("mid_rst_done", Done, 0);
    @(posedge CLK);
    #2 rst = 1'b0;
    d0 = done_cnt;
    repeat (12) @(negedge CLK);
    chk("mid_rst_no_done", done_cnt - d0, 0);
    lit("d14_3", 14, 3, 4, 2, 0, 5);

    // Exhaustive sweep, back-to-back at the earliest legal Go.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        start(x, y);
        wait_done("sweep", lat);
        if (y != 0) begin
          chk("sweep_identity", int'(Q) * y + int'(R), x);
          chk("sweep_r_lt_y", (int'(R) < y) ? 1 : 0, 1);
        end
        chk("sweep_err", Err, (y == 0) ? 1 : 0);
      end
    end

    repeat (5) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
